// File: rtl/rpc2_ctrl_rd_stream_pkg.sv
// rpc2_ctrl_rd_stream_pkg: shared types and constants for the FIFO read-stream engine
package rpc2_ctrl_rd_stream_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int SKID_DEPTH = 3;
    localparam int STAT_W     = 16;

    // Occupancy value meaning "buffer full", sized to the occupancy counter.
    localparam logic [1:0] SKID_FULL = 2'(SKID_DEPTH);

    // Circular pointer advance over the SKID_DEPTH entries.
    function automatic logic [1:0] skid_ptr_next(input logic [1:0] p);
        return (p == SKID_FULL - 2'd1) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/rpc2_ctrl_skid_buf.sv
// rpc2_ctrl_skid_buf: 3-entry in-order buffer absorbing FIFO read latency; burst-agnostic
module rpc2_ctrl_skid_buf
    import rpc2_ctrl_rd_stream_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [SKID_DEPTH];
    logic [1:0]   rd_ptr;
    logic [1:0]   wr_ptr;
    logic         wr_en;
    logic         rd_en;

    // A push into a full buffer or a pop from an empty one is dropped.
    assign wr_en     = push && (occ != SKID_FULL);
    assign rd_en     = pop && (occ != 2'd0);
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy tracking; simultaneous push/pop keeps occ unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            occ    <= 2'd0;
        end else begin
            rd_ptr <= rd_en ? skid_ptr_next(rd_ptr) : rd_ptr;
            wr_ptr <= wr_en ? skid_ptr_next(wr_ptr) : wr_ptr;
            occ    <= occ + {1'b0, wr_en} - {1'b0, rd_en};
        end
    end

    // Storage needs no reset: contents are only observed while occ is non-zero.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rpc2_ctrl_fifo_rd_stream.sv
// rpc2_ctrl_fifo_rd_stream: drains a FIFO into length-programmed valid/ready bursts.
// Optional starvation counter stat_stall_cnt enabled by RPC2_CTRL_RD_STREAM_STAT_EN.
module rpc2_ctrl_fifo_rd_stream
    import rpc2_ctrl_rd_stream_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = 16,
    parameter int LEN_BITS        = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                       len_valid,
    output logic                       len_ready,
    input  logic [LEN_BITS-1:0]        len,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [FIFO_DATA_WIDTH-1:0] o_data,
    output logic                       o_last,
    output logic                       busy
`ifdef RPC2_CTRL_RD_STREAM_STAT_EN
    ,
    output logic [STAT_W-1:0]          stat_stall_cnt
`endif
);

    state_t                     state;
    logic [LEN_BITS:0]          rd_left;
    logic [LEN_BITS:0]          beat_left;
    logic                       inflight;
    logic [1:0]                 occ;
    logic [FIFO_DATA_WIDTH-1:0] head_data;
    logic                       accept;

    assign len_ready = (state == IDLE);
    assign busy      = (state == BURST);
    assign o_valid   = (occ != 2'd0);
    assign o_data    = o_valid ? head_data : '0;
    assign o_last    = o_valid && (beat_left == (LEN_BITS+1)'(1));
    assign accept    = o_valid && o_ready;

    // Fetch only while the buffer plus the word in flight leaves room; o_ready is
    // deliberately not used so there is no combinational ready-to-pop path.
    assign fifo_rd_en = busy && !fifo_empty && (rd_left != '0) &&
                        (({1'b0, occ} + {2'b0, inflight}) < 3'(SKID_DEPTH));

    // Burst control: load counters at the command handshake, count fetches and beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_left   <= '0;
            beat_left <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (state == IDLE) begin
                if (len_valid) begin
                    state     <= BURST;
                    rd_left   <= {1'b0, len} + 1'b1;
                    beat_left <= {1'b0, len} + 1'b1;
                end
            end else begin
                rd_left   <= fifo_rd_en ? rd_left - 1'b1 : rd_left;
                beat_left <= accept ? beat_left - 1'b1 : beat_left;
                state     <= (accept && o_last) ? IDLE : BURST;
            end
        end
    end

    rpc2_ctrl_skid_buf #(
        .W(FIFO_DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (fifo_rd_data),
        .pop       (accept),
        .head_data (head_data),
        .occ       (occ)
    );

`ifdef RPC2_CTRL_RD_STREAM_STAT_EN
    // Count burst cycles with nothing to present, saturating; restart per command.
    always_ff @(posedge clk) begin
        if (rst || (len_valid && len_ready)) begin
            stat_stall_cnt <= '0;
        end else if (busy && !o_valid && (stat_stall_cnt != '1)) begin
            stat_stall_cnt <= stat_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rpc2_ctrl_fifo_rd_stream.sv
// tb_rpc2_ctrl_fifo_rd_stream: randomized self-checking bench with a FIFO model and beat scoreboard
module tb_rpc2_ctrl_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data = '0;
    logic        len_valid = 1'b0;
    logic        len_ready;
    logic [7:0]  len = '0;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic [15:0] o_data;
    logic        o_last;
    logic        busy;
`ifdef RPC2_CTRL_RD_STREAM_STAT_EN
    logic [15:0] stat_stall_cnt;
`endif

    rpc2_ctrl_fifo_rd_stream #(
        .FIFO_DATA_WIDTH(16),
        .LEN_BITS       (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_rd_data   (fifo_rd_data),
        .len_valid      (len_valid),
        .len_ready      (len_ready),
        .len            (len),
        .o_valid        (o_valid),
        .o_ready        (o_ready),
        .o_data         (o_data),
        .o_last         (o_last),
        .busy           (busy)
`ifdef RPC2_CTRL_RD_STREAM_STAT_EN
        ,
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // FIFO model: array with pointers, data valid the cycle after the pop request.
    logic [15:0] fifo_mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        stall_empty = 1'b0;
    logic        stall_rand  = 1'b0;

    assign fifo_empty = stall_empty || stall_rand || (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= fifo_mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    task automatic push_word(input logic [15:0] d);
        fifo_mem[wr_ptr] = d;
        wr_ptr++;
    endtask

    // Downstream ready / FIFO starvation driver: 0 always ready, 1 random, 2 pattern 1,0,0, 3 never.
    int rdy_mode = 0;
    initial begin
        int tog = 0;
        forever begin
            @(posedge clk);
            #1;
            o_ready    = (rdy_mode == 0) ? 1'b1 :
                         (rdy_mode == 1) ? 1'($urandom_range(0, 1)) :
                         (rdy_mode == 2) ? (tog % 3 == 0) : 1'b0;
            stall_rand = (rdy_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
            tog++;
        end
    end

    // Scoreboard: beats must reproduce FIFO order, o_last exactly on beat len+1 of each command.
    int          cmd_q[$];
    int          exp_idx = 0;
    int          beat_n = 0;
    int          beats = 0;
    bit          resync = 1'b1;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    bit          in_burst = 1'b0;
    int          m_stall = 0;

    always @(negedge clk) begin
        if (rst) begin
            resync = 1'b1;
            cmd_q.delete();
            beat_n = 0;
            prev_stall = 1'b0;
            in_burst = 1'b0;
            m_stall = 0;
        end else begin
            if (resync) begin
                exp_idx = rd_ptr;
                resync = 1'b0;
            end
`ifdef RPC2_CTRL_RD_STREAM_STAT_EN
            chk("stall_cnt", stat_stall_cnt, m_stall);
`endif
            if (fifo_rd_en) chk("pop_nonempty", fifo_empty, 1'b0);
            if (prev_stall) begin
                chk("hold_valid", o_valid, 1'b1);
                chk("hold_data", o_data, prev_data);
            end
            if (o_valid) begin
                if (cmd_q.size() == 0) chk("beat_no_cmd", cmd_q.size(), 1);
                else chk("last", o_last, beat_n == cmd_q[0]);
            end
            if (o_valid && o_ready && cmd_q.size() != 0) begin
                chk("data", o_data, fifo_mem[exp_idx]);
                exp_idx++;
                beats++;
                if (beat_n == cmd_q[0]) begin
                    void'(cmd_q.pop_front());
                    beat_n = 0;
                    in_burst = 1'b0;
                end else begin
                    beat_n++;
                end
            end
            if (in_burst && !o_valid && m_stall != 16'hffff) m_stall++;
            if (len_valid && len_ready) begin
                cmd_q.push_back(int'(len));
                m_stall = 0;
                in_burst = 1'b1;
            end
            prev_stall = o_valid && !o_ready;
            prev_data  = o_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command and return one cycle after the handshake edge.
    task automatic send(input int l);
        int t = 0;
        len = 8'(l);
        len_valid = 1'b1;
        while (!len_ready && t < 3000) begin
            step();
            t++;
        end
        if (t >= 3000) chk("send_timeout", len_ready, 1'b1);
        step();
        len_valid = 1'b0;
        len = 8'($urandom);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) chk("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int b0;
        int n;
        int tot;
        repeat (3) step();
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_last", o_last, 1'b0);
        chk("rst_data", o_data, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_len_ready", len_ready, 1'b1);
`ifdef RPC2_CTRL_RD_STREAM_STAT_EN
        chk("rst_stall", stat_stall_cnt, 16'h0);
`endif
        rst = 1'b0;
        step();

        // Single-beat burst and its exact latency.
        rdy_mode = 0;
        push_word(16'h1234);
        start = rd_ptr;
        b0 = beats;
        send(0);
        chk("t1_rd_en_c1", fifo_rd_en, 1'b1);
        chk("t1_busy_c1", busy, 1'b1);
        step();
        chk("t1_valid_c2", o_valid, 1'b0);
        chk("t1_rd_en_c2", fifo_rd_en, 1'b0);
        step();
        chk("t1_valid_c3", o_valid, 1'b1);
        chk("t1_data_c3", o_data, 16'h1234);
        chk("t1_last_c3", o_last, 1'b1);
        step();
        chk("t1_busy_c4", busy, 1'b0);
        chk("t1_len_ready_c4", len_ready, 1'b1);
        chk("t1_pops", rd_ptr - start, 1);
        chk("t1_beats", beats - b0, 1);

        // Four-beat burst at full rate.
        start = rd_ptr;
        b0 = beats;
        for (int i = 0; i < 4; i++) push_word(16'(16'hA0 + i));
        send(3);
        wait_idle(n);
        chk("t2_cycles", n, 6);
        chk("t2_pops", rd_ptr - start, 4);
        chk("t2_beats", beats - b0, 4);

        // Eight beats under a 1,0,0 ready pattern.
        rdy_mode = 2;
        start = rd_ptr;
        b0 = beats;
        for (int i = 0; i < 8; i++) push_word(16'($urandom));
        send(7);
        wait_idle(n);
        chk("t3_pops", rd_ptr - start, 8);
        chk("t3_beats", beats - b0, 8);

        // Back-to-back bursts drain exactly the 12 words present.
        rdy_mode = 0;
        start = rd_ptr;
        b0 = beats;
        for (int i = 0; i < 12; i++) push_word(16'($urandom));
        send(3);
        send(7);
        wait_idle(n);
        chk("t4_pops", rd_ptr - start, 12);
        chk("t4_fifo_left", wr_ptr - rd_ptr, 0);
        chk("t4_beats", beats - b0, 12);

        // FIFO runs dry after two words for ten cycles.
        start = rd_ptr;
        b0 = beats;
        for (int i = 0; i < 6; i++) push_word(16'($urandom));
        send(5);
        n = 0;
        while (rd_ptr - start < 2 && n < 100) begin
            step();
            n++;
        end
        stall_empty = 1'b1;
        repeat (10) step();
        chk("t5_beats_in_gap", beats - b0, 2);
        chk("t5_valid_in_gap", o_valid, 1'b0);
        stall_empty = 1'b0;
        wait_idle(n);
        chk("t5_pops", rd_ptr - start, 6);
        chk("t5_beats", beats - b0, 6);

        // Reset with beats buffered, then a fresh single-beat command.
        rdy_mode = 3;
        for (int i = 0; i < 8; i++) push_word(16'($urandom));
        send(7);
        repeat (5) step();
        chk("t6_valid_before_rst", o_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid_after_rst", o_valid, 1'b0);
        chk("t6_busy_after_rst", busy, 1'b0);
        chk("t6_len_ready_after_rst", len_ready, 1'b1);
        chk("t6_last_after_rst", o_last, 1'b0);
        repeat (3) step();
        chk("t6_no_beat_after_rst", o_valid, 1'b0);
        rdy_mode = 0;
        start = rd_ptr;
        b0 = beats;
        send(0);
        wait_idle(n);
        chk("t6_pops", rd_ptr - start, 1);
        chk("t6_beats", beats - b0, 1);

        // Maximum length burst: 256 beats, no counter wrap.
        start = rd_ptr;
        b0 = beats;
        for (int i = 0; i < 256; i++) push_word(16'($urandom));
        send(255);
        wait_idle(n);
        chk("t7_pops", rd_ptr - start, 256);
        chk("t7_beats", beats - b0, 256);

        // Random lengths, random ready and random FIFO starvation.
        rdy_mode = 1;
        start = rd_ptr;
        b0 = beats;
        tot = 0;
        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(0, 15);
            tot += n + 1;
            for (int i = 0; i <= n; i++) push_word(16'($urandom));
            send(n);
        end
        wait_idle(n);
        chk("t8_pops", rd_ptr - start, tot);
        chk("t8_beats", beats - b0, tot);
        rdy_mode = 0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
